ddram_verify: RTL and testbench

//  Read-side counterpart of the menu core's DDR3 clearer. It burst-reads a DDR3 address

---
 rtl/ddram_verify_pkg.sv | 28 ++
 rtl/ddram_verify_cmp.sv | 42 ++++
 rtl/ddram_verify.sv | 123 ++++++++++++
 tb/tb_ddram_verify.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddram_verify_pkg.sv
// Shared types and helpers for the DDR3 read-back verifier.
// Build option: DDRAM_VERIFY_PATTERN_EN selects the address-derived fill pattern.
package ddram_verify_pkg;

    localparam int ADDR_W = 29;
    localparam int DATA_W = 64;
    localparam int BCNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA,
        DONE
    } state_t;

    // Value the clearer wrote at beat address a.
    function automatic logic [DATA_W-1:0] exp_word(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] fill
    );
`ifdef DDRAM_VERIFY_PATTERN_EN
        exp_word = {~{3'b000, a}, {3'b000, a}};
`else
        exp_word = fill;
`endif
    endfunction

endpackage

// File: rtl/ddram_verify_cmp.sv
// Registered beat compare and error accumulator for ddram_verify.
// Ports: clk_sys, RESET (sync, active-low), clr, valid, addr, data,
//        expected in; err, err_cnt (saturating), err_addr (first miss) out.
module ddram_verify_cmp
    import ddram_verify_pkg::*;
(
    input  logic              clk_sys,
    input  logic              RESET,
    input  logic              clr,
    input  logic              valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] expected,
    output logic              err,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] err_addr
);

    logic miss;

    assign miss = valid && (data != expected);

    always_ff @(posedge clk_sys) begin
        if (!RESET) begin
            err      <= 1'b0;
            err_cnt  <= '0;
            err_addr <= '0;
        end else if (clr) begin
            err      <= 1'b0;
            err_cnt  <= '0;
            err_addr <= '0;
        end else if (miss) begin
            err <= 1'b1;
            if (err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
            // only the first failing beat of a pass is remembered
            if (!err)
                err_addr <= addr;
        end
    end

endmodule

// File: rtl/ddram_verify.sv
// Burst-reads a DDR3 word window and checks each beat against the fill value.
// Ports: clk_sys, RESET (sync, active-low), start in; busy, done, err,
//        err_cnt, err_addr out; DDRAM_* avalon-style read master.
// Build option: DDRAM_VERIFY_PATTERN_EN (address pattern instead of EXPECT).
module ddram_verify
    import ddram_verify_pkg::*;
#(
    parameter int unsigned       BURST      = 128,
    parameter logic [ADDR_W-1:0] ADDR_START = 29'h0,
    parameter logic [ADDR_W-1:0] ADDR_END   = 29'h3FFFFF,
    parameter logic [DATA_W-1:0] EXPECT     = 64'h0
) (
    input  logic              clk_sys,
    input  logic              RESET,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] err_addr,
    input  logic              DDRAM_BUSY,
    output logic [BCNT_W-1:0] DDRAM_BURSTCNT,
    output logic [ADDR_W-1:0] DDRAM_ADDR,
    output logic              DDRAM_RD,
    input  logic [DATA_W-1:0] DDRAM_DOUT,
    input  logic              DDRAM_DOUT_READY
);

    localparam logic [ADDR_W:0] BURST_X = (ADDR_W + 1)'(BURST);
    localparam logic [ADDR_W:0] ONE_X   = (ADDR_W + 1)'(1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr, addr_nx;
    logic [BCNT_W-1:0] beat, beat_nx;
    logic [ADDR_W:0]   rem;
    logic [BCNT_W-1:0] bcnt;
    logic              last_burst;
    logic              burst_full;
    logic              beat_ok;
    logic              clr;
    logic [ADDR_W-1:0] beat_addr;
    logic [DATA_W-1:0] expected;

    // one extra bit so a window ending at the top word cannot wrap
    assign rem        = {1'b0, ADDR_END} - {1'b0, addr} + ONE_X;
    assign last_burst = (rem <= BURST_X);
    assign bcnt       = last_burst ? rem[BCNT_W-1:0] : BCNT_W'(BURST);

    // burst_full stays high one cycle after the last beat so its
    // compare lands before done/next request
    assign burst_full = (beat == bcnt);
    assign beat_ok    = DDRAM_DOUT_READY && (state == DATA) && !burst_full;
    assign beat_addr  = addr + ADDR_W'(beat);
    assign expected   = exp_word(beat_addr, EXPECT);

    always_ff @(posedge clk_sys) begin
        if (!RESET) begin
            state <= IDLE;
            addr  <= ADDR_START;
            beat  <= '0;
        end else begin
            state <= state_nx;
            addr  <= addr_nx;
            beat  <= beat_nx;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        beat_nx  = beat;
        clr      = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = REQ;
                    addr_nx  = ADDR_START;
                    beat_nx  = '0;
                    clr      = 1'b1;
                end
            end
            REQ: begin
                if (!DDRAM_BUSY) begin
                    state_nx = DATA;
                    beat_nx  = '0;
                end
            end
            DATA: begin
                if (burst_full) begin
                    if (last_burst) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = REQ;
                        addr_nx  = addr + ADDR_W'(bcnt);
                    end
                end else if (beat_ok) begin
                    beat_nx = beat + BCNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy           = (state == REQ) || (state == DATA);
    assign done           = (state == DONE);
    assign DDRAM_RD       = (state == REQ);
    assign DDRAM_ADDR     = DDRAM_RD ? addr : '0;
    assign DDRAM_BURSTCNT = DDRAM_RD ? bcnt : '0;

    ddram_verify_cmp u_cmp (
        .clk_sys  (clk_sys),
        .RESET    (RESET),
        .clr      (clr),
        .valid    (beat_ok),
        .addr     (beat_addr),
        .data     (DDRAM_DOUT),
        .expected (expected),
        .err      (err),
        .err_cnt  (err_cnt),
        .err_addr (err_addr)
    );

endmodule

// File: tb/tb_ddram_verify.sv
// Self-checking bench for ddram_verify: DDR read responder plus
// request/result scoreboard across three window configurations.
module tb_ddram_verify;

    localparam int NI    = 3;
    localparam int BURST = 128;
    localparam logic [28:0] STARTS [NI] = '{29'd0, 29'd0, 29'd16};
    localparam logic [28:0] ENDS   [NI] = '{29'd255, 29'd299, 29'd70015};

    logic          clk_sys = 1'b0;
    logic          RESET   = 1'b0;
    logic [NI-1:0] start_a = '0;
    logic [NI-1:0] busy_a, done_a, err_a, rd_a;
    logic [15:0]   ecnt_a  [NI];
    logic [28:0]   eaddr_a [NI];
    logic [28:0]   ad_a    [NI];
    logic [7:0]    bc_a    [NI];
    logic          ddr_busy = 1'b0;
    logic          ddr_rdy  = 1'b0;
    logic [63:0]   ddr_dout = '0;

    int  n_chk = 0;
    int  n_err = 0;
    int  act   = 0;
    bit  stall   = 1'b0;
    bit  all_bad = 1'b0;
    int  beats    = 0;
    int  stab_bad = 0;
    logic [63:0] corrupt [int];
    logic [36:0] req_q [$];
    logic [44:0] res_q [$];

    always #5 clk_sys = ~clk_sys;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ddram_verify #(
            .BURST      (BURST),
            .ADDR_START (STARTS[g]),
            .ADDR_END   (ENDS[g]),
            .EXPECT     (64'h0)
        ) u_dut (
            .clk_sys          (clk_sys),
            .RESET            (RESET),
            .start            (start_a[g]),
            .busy             (busy_a[g]),
            .done             (done_a[g]),
            .err              (err_a[g]),
            .err_cnt          (ecnt_a[g]),
            .err_addr         (eaddr_a[g]),
            .DDRAM_BUSY       (ddr_busy),
            .DDRAM_BURSTCNT   (bc_a[g]),
            .DDRAM_ADDR       (ad_a[g]),
            .DDRAM_RD         (rd_a[g]),
            .DDRAM_DOUT       (ddr_dout),
            .DDRAM_DOUT_READY (ddr_rdy)
        );
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] good(input logic [28:0] a);
`ifdef DDRAM_VERIFY_PATTERN_EN
        return {~{3'b000, a}, {3'b000, a}};
`else
        return 64'h0;
`endif
    endfunction

    function automatic logic [63:0] mem_word(input logic [28:0] a);
        if (all_bad)
            return 64'hDEAD;
        if (corrupt.exists(int'(a)))
            return corrupt[int'(a)];
        return good(a);
    endfunction

    // model of the pass: expected requests and final error summary
    task automatic plan(input int g);
        int s, e, c, n, first;
        bit seen;
        s = int'(STARTS[g]);
        e = int'(ENDS[g]);
        req_q.delete();
        res_q.delete();
        for (int x = s; x <= e; x += BURST) begin
            c = (e - x + 1 < BURST) ? (e - x + 1) : BURST;
            req_q.push_back({29'(x), 8'(c)});
        end
        n = 0;
        first = 0;
        seen = 1'b0;
        for (int x = s; x <= e; x++) begin
            if (mem_word(29'(x)) !== good(29'(x))) begin
                if (!seen)
                    first = x;
                seen = 1'b1;
                n++;
            end
        end
        if (n > 65535)
            n = 65535;
        res_q.push_back({16'(n), 29'(first)});
    endtask

    task automatic start_pulse(input int g);
        act = g;
        beats = 0;
        stab_bad = 0;
        plan(g);
        start_a[g] = 1'b1;
        @(posedge clk_sys);
        #1;
        start_a[g] = 1'b0;
    endtask

    task automatic run_pass(input int g, input string tag, input int budget);
        logic [44:0] r;
        start_pulse(g);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_sys);
            #1;
            if (done_a[g])
                break;
        end
        chk({tag, "_done"}, 64'(done_a[g]), 64'd1);
        chk({tag, "_busy"}, 64'(busy_a[g]), 64'd0);
        r = (res_q.size() != 0) ? res_q.pop_front() : '1;
        chk({tag, "_cnt"}, 64'(ecnt_a[g]), 64'(r[44:29]));
        chk({tag, "_addr"}, 64'(eaddr_a[g]), 64'(r[28:0]));
        chk({tag, "_err"}, 64'(err_a[g]), 64'(r[44:29] != 16'd0));
        chk({tag, "_beats"}, 64'(beats),
            64'(int'(ENDS[g]) - int'(STARTS[g]) + 1));
        chk({tag, "_reqleft"}, 64'(req_q.size()), 64'd0);
        chk({tag, "_stable"}, 64'(stab_bad), 64'd0);
    endtask

    initial begin
        fork
            begin : resp
                int pend;
                int st;
                logic [28:0] pa, h_ad;
                logic [7:0]  h_bc;
                logic [36:0] exp_req;
                pend = 0;
                st = 0;
                pa = '0;
                h_ad = '0;
                h_bc = '0;
                forever begin
                    @(negedge clk_sys);
                    ddr_rdy = 1'b0;
                    if (!RESET) begin
                        pend = 0;
                        st = 0;
                        ddr_busy = 1'b0;
                    end else if (pend > 0) begin
                        ddr_dout = mem_word(pa);
                        ddr_rdy = 1'b1;
                        pa = pa + 29'd1;
                        pend--;
                        beats++;
                    end else if (rd_a[act]) begin
                        if (st > 0 && (ad_a[act] !== h_ad ||
                                       bc_a[act] !== h_bc))
                            stab_bad++;
                        if (stall && st < 10) begin
                            if (st == 0) begin
                                h_ad = ad_a[act];
                                h_bc = bc_a[act];
                            end
                            st++;
                            ddr_busy = 1'b1;
                        end else begin
                            ddr_busy = 1'b0;
                            st = 0;
                            pa = ad_a[act];
                            pend = int'(bc_a[act]);
                            exp_req = (req_q.size() != 0) ?
                                      req_q.pop_front() : '1;
                            chk("req", 64'({ad_a[act], bc_a[act]}),
                                64'(exp_req));
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_busy", 64'(busy_a[1]), 64'd0);
        chk("rst_done", 64'(done_a[1]), 64'd0);
        chk("rst_err", 64'(err_a[1]), 64'd0);
        chk("rst_cnt", 64'(ecnt_a[1]), 64'd0);
        chk("rst_rd", 64'(rd_a[1]), 64'd0);
        chk("rst_bc", 64'(bc_a[1]), 64'd0);
        RESET = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;

        run_pass(0, "w256", 5000);

        corrupt[5] = 64'h1;
        corrupt[32'h9A] = 64'hFF;
        run_pass(1, "w300", 5000);

        stall = 1'b1;
        run_pass(1, "stall", 8000);
        stall = 1'b0;

        corrupt.delete();
        corrupt[5] = 64'h1;
        start_pulse(1);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk_sys);
            #1;
            if (beats >= 60)
                break;
        end
        chk("mid_beats", 64'(beats >= 60), 64'd1);
        chk("mid_cnt", 64'(ecnt_a[1]), 64'd1);
        RESET = 1'b0;
        @(posedge clk_sys);
        #1;
        chk("abort_rd", 64'(rd_a[1]), 64'd0);
        chk("abort_busy", 64'(busy_a[1]), 64'd0);
        chk("abort_cnt", 64'(ecnt_a[1]), 64'd0);
        chk("abort_err", 64'(err_a[1]), 64'd0);
        chk("abort_done", 64'(done_a[1]), 64'd0);
        repeat (2) @(posedge clk_sys);
        #1;
        RESET = 1'b1;
        @(posedge clk_sys);
        #1;
        run_pass(1, "rerun", 5000);

        corrupt.delete();
        corrupt[7] = good(29'd7) ^ 64'h1;
        run_pass(1, "flip7", 5000);
        chk("flip7_at7", 64'(eaddr_a[1]), 64'd7);

        corrupt.delete();
        all_bad = 1'b1;
        run_pass(2, "sat", 80000);
        chk("sat_max", 64'(ecnt_a[2]), 64'hFFFF);
        chk("sat_first", 64'(eaddr_a[2]), 64'd16);
        all_bad = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
